// File: rtl/rr_mux_arbiter_4_if.sv
// Purpose: handshake/data bundle between four requesters, the arbiter and one consumer.
// Latency: none (wires only).
// Backpressure: in_ready per requester, out_ready from the consumer.
//
// Signals:
//   in_valid[3:0]   requester i presents in_data<i>
//   in_data0..3     requester data, WIDTH bits each
//   in_ready[3:0]   requester i's word is taken this cycle (one-hot or zero)
//   out_valid       output register holds a word
//   out_data        granted word
//   out_sel         index of the requester that produced out_data
//   out_ready       consumer accepts the word this cycle
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters plus consumer)
interface rr_mux_arbiter_4_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  modport slave (
    input  in_valid,
    input  in_data0,
    input  in_data1,
    input  in_data2,
    input  in_data3,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data0,
    output in_data1,
    output in_data2,
    output in_data3,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// Purpose: round-robin arbiter sharing one 4:1 mux among four valid/ready requesters.
// Latency: 1 cycle from accepted request to out_valid/out_data/out_sel.
// Backpressure: output register loads when empty or draining; otherwise in_ready is all zero.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; clears output register and pointer
//   bus    - rr_mux_arbiter_4_if.slave: in_valid/in_data0..3/in_ready on the
//            requester side, out_valid/out_data/out_sel/out_ready on the consumer side
module rr_mux_arbiter_4 #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_mux_arbiter_4_if.slave   bus
);

  // Round-robin pointer: the requester that has highest priority this cycle.
  logic [1:0]       ptr_q;

  // Output register.
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_sel_q;

  logic             accept;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] mux_dat;
  logic [3:0]       in_ready_w;
  logic             xfer;

  // The output stage can take a word when it is empty or being drained now.
  assign accept = !out_valid_q || bus.out_ready;

  // Grant search from ptr upward (mod 4). Walking offsets from the far end
  // back to offset 0 lets the nearest valid requester overwrite any farther
  // one, so no early exit is needed.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    scan_idx    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (bus.in_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Ready is gated by rst_n so nothing is handed off while reset is asserted,
  // even between clock edges.
  always_comb begin
    in_ready_w = 4'b0000;
    if (accept && rst_n && grant_found) begin
      in_ready_w = 4'b0001 << grant_idx;
    end
  end

  assign bus.in_ready = in_ready_w;
  assign xfer         = |(bus.in_valid & in_ready_w);

  // Shared datapath: only the grant index steers the mux; data never feeds
  // back into any control signal.
  always_comb begin
    mux_dat = bus.in_data0;
    case (grant_idx)
      2'd0:    mux_dat = bus.in_data0;
      2'd1:    mux_dat = bus.in_data1;
      2'd2:    mux_dat = bus.in_data2;
      default: mux_dat = bus.in_data3;
    endcase
  end

  // A load takes priority over a drain, so a word accepted in the same cycle
  // the previous one leaves keeps out_valid high with the new contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else if (xfer) begin
      ptr_q       <= grant_idx + 2'd1;
      out_valid_q <= 1'b1;
      out_data_q  <= mux_dat;
      out_sel_q   <= grant_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Purpose: self-checking bench for rr_mux_arbiter_4 (directed table, corner sequences, random vs model).
// Latency: checks outputs 1 cycle after each accepted request.
// Backpressure: drives out_ready low in directed and random phases.
module tb_rr_mux_arbiter_4;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;

  rr_mux_arbiter_4_if #(.WIDTH(WIDTH)) bus ();

  rr_mux_arbiter_4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] d0, d1, d2, d3;
    logic       ordy;
    logic [3:0] rdy;   // expected in_ready before the edge
    logic       ov;    // expected outputs after the edge
    logic [3:0] od;
    logic [1:0] os;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] vld,
                              input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input logic ordy, input logic [3:0] rdy,
                              input logic ov, input logic [3:0] od, input logic [1:0] os);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.od = od; v.os = os;
    return v;
  endfunction

  task automatic drive(input logic [3:0] vld, input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3, input logic ordy);
    bus.in_valid  = vld;
    bus.in_data0  = d0;
    bus.in_data1  = d1;
    bus.in_data2  = d2;
    bus.in_data3  = d3;
    bus.out_ready = ordy;
  endtask

  // Reference model state.
  int         m_ptr;
  logic       m_vld;
  logic [3:0] m_data;
  logic [1:0] m_sel;

  // Requester i wins if valid and nearest to ptr going upward mod 4.
  function automatic int model_grant(input logic [3:0] vld, input int ptr);
    int best_dist = 4;
    int g = -1;
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && ((i - ptr + 4) % 4) < best_dist) begin
        best_dist = (i - ptr + 4) % 4;
        g = i;
      end
    end
    return g;
  endfunction

  logic [3:0] pend;
  logic [3:0] pdat [4];
  int         waitx [4];

  initial begin
    rst_n = 1'b1;
    drive(4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);

    // Reset takes effect without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_sel",   32'(bus.out_sel),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);

    // Round-robin sweep.
    vecs.push_back(mk(1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0001, 1, 4'hA, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0010, 1, 4'hB, 2'd1));
    vecs.push_back(mk(1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0100, 1, 4'hC, 2'd2));
    vecs.push_back(mk(1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b1000, 1, 4'hD, 2'd3));
    vecs.push_back(mk(1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0001, 1, 4'hA, 2'd0));
    // Pointer skip.
    vecs.push_back(mk(0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 4'h0, 2'd0));
    vecs.push_back(mk(1, 4'b0100, 4'h0, 4'h0, 4'h7, 4'h0, 1, 4'b0100, 1, 4'h7, 2'd2));
    vecs.push_back(mk(1, 4'b1010, 4'h0, 4'h3, 4'h0, 4'h9, 1, 4'b1000, 1, 4'h9, 2'd3));
    vecs.push_back(mk(1, 4'b0010, 4'h0, 4'h3, 4'h0, 4'h0, 1, 4'b0010, 1, 4'h3, 2'd1));
    // Backpressure.
    vecs.push_back(mk(0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 4'h0, 2'd0));
    vecs.push_back(mk(1, 4'b0001, 4'h5, 4'h0, 4'h0, 4'h0, 1, 4'b0001, 1, 4'h5, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'b0000, 1, 4'h5, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'b0000, 1, 4'h5, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'b0000, 1, 4'h5, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0010, 1, 4'h2, 2'd1));
    // Drain to idle, then the held pointer (2) picks requester 2.
    vecs.push_back(mk(1, 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0000, 0, 4'h2, 2'd1));
    vecs.push_back(mk(1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1, 4'b0100, 1, 4'h3, 2'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst;
      drive(vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
      check($sformatf("vec%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].od));
      check($sformatf("vec%0d_out_sel", i),   32'(bus.out_sel),   32'(vecs[i].os));
    end

    // Reset mid-stream at out_sel = 2.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_sel_before", 32'(bus.out_sel), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data",  32'(bus.out_data),  32'd0);
    check("mid_rst_out_sel",   32'(bus.out_sel),   32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(bus.in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("mid_rel_out_valid", 32'(bus.out_valid), 32'd1);
    check("mid_rel_out_data",  32'(bus.out_data),  32'hA);
    check("mid_rel_out_sel",   32'(bus.out_sel),   32'd0);

    // Random traffic against the model.
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    m_ptr = 0; m_vld = 1'b0; m_data = 4'h0; m_sel = 2'd0;
    pend = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      pdat[i] = 4'h0;
      waitx[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 400; cyc++) begin
      logic       ordy;
      logic       acc;
      int         g;
      logic [3:0] exp_rdy;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i]  = 1'b1;
          pdat[i]  = 4'($urandom);
          waitx[i] = 0;
        end
      end
      ordy = ($urandom_range(3, 0) != 0);
      drive(pend, pdat[0], pdat[1], pdat[2], pdat[3], ordy);
      #1;
      g = model_grant(pend, m_ptr);
      acc = !m_vld || ordy;
      exp_rdy = (acc && g >= 0) ? (4'b0001 << g) : 4'b0000;
      check($sformatf("rnd%0d_in_ready", cyc), 32'(bus.in_ready), 32'(exp_rdy));
      if (acc && g >= 0) begin
        check($sformatf("rnd%0d_fair_req%0d", cyc, g), 32'(waitx[g] <= 3), 32'd1);
        for (int j = 0; j < 4; j++) begin
          if (pend[j] && j != g) waitx[j]++;
        end
        m_vld  = 1'b1;
        m_data = pdat[g];
        m_sel  = 2'(g);
        m_ptr  = (g + 1) % 4;
        pend[g] = 1'b0;
      end else if (m_vld && ordy) begin
        m_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_out_valid", cyc), 32'(bus.out_valid), 32'(m_vld));
      check($sformatf("rnd%0d_out_data", cyc),  32'(bus.out_data),  32'(m_data));
      check($sformatf("rnd%0d_out_sel", cyc),   32'(bus.out_sel),   32'(m_sel));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_4.md
# rr_mux_arbiter_4

Round-robin arbiter that shares one 4-to-1 mux datapath among four valid/ready requesters. Each cycle it picks at most one requester, steers that requester's data through the mux, and captures the result in a single registered output stage with its own valid/ready handshake. It sits between four independent producers and one consumer of the shared `WIDTH`-bit path.

## Interface

Parameters:
- `WIDTH`, default 4: data width of every requester and of the output.

Ports:
- `clk`  input  1: single clock. All state changes on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `in_valid`  input  4: bit i means requester i presents data.
- `in_data0`, `in_data1`, `in_data2`, `in_data3`  input  `WIDTH` each: requester data.
- `in_ready`  output  4: bit i means requester i's data is taken this cycle.
- `out_valid`  output  1: the output register holds a word.
- `out_data`  output  `WIDTH`: the granted word.
- `out_sel`  output  2: index of the requester that produced `out_data`.
- `out_ready`  input  1: the consumer accepts the word this cycle.

## Operation

- State: output register (`out_valid`, `out_data`, `out_sel`) and a 2-bit round-robin pointer `ptr`.
- `accept = !out_valid || out_ready`. The output stage can load this cycle.
- Grant search: scan requesters in order `ptr, ptr+1, ptr+2, ptr+3`, mod 4. The first one with `in_valid` set wins.
- The grant index drives the select of the shared 4-to-1 mux. Data path: `in_data0..3` to the mux to the output register.
- `in_ready[i] = accept && rst_n && (i == grant) && in_valid[i]`. This is combinational. At most one bit is set.
- Transfer on requester i (`in_valid[i] && in_ready[i]`):
  - `out_data <= in_data_i`
  - `out_sel <= i`
  - `out_valid <= 1`
  - `ptr <= (i + 1) mod 4`, wrapping from 3 to 0.
- No transfer, with `out_valid && out_ready`: `out_valid <= 0`. `out_data` and `out_sel` keep their values.
- No transfer, with `!out_ready`: all state holds.
- `ptr` changes only on a transfer. If no requester is valid, `ptr` holds.
- Simultaneous drain and load in the same cycle: the load wins, `out_valid` stays 1, and the new word replaces the old one.
- Fairness: a requester that holds `in_valid` high is granted within 4 output transfers.
- Requesters must not drop `in_valid` or change `in_data` until their `in_ready` is seen. The consumer sees `out_data` and `out_sel` stable while `out_valid && !out_ready`.

## Timing

- Reset (`rst_n` = 0, takes effect immediately, no clock needed):
  - `out_valid` = 0
  - `out_data` = 0
  - `out_sel` = 0
  - `ptr` = 0
  - `in_ready` = 0000
- Latency: 1 cycle. A word accepted at edge N appears on `out_*` after edge N.
- Throughput: 1 word per cycle while `out_ready` is held at 1 and any requester is valid.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `ptr`. There are no combinational paths from `in_data*` to any control output.
- Reset asserted mid-operation: any word in flight is discarded. `ptr` returns to 0. The first grant after reset release goes to the lowest-index valid requester.

## Test plan

1. Reset check: assert `rst_n`=0 with all `in_valid`=1111 and `out_ready`=1. Required: `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0000, with no clock edge needed.
2. Round-robin sweep: release reset. Hold `in_valid`=1111, `in_data0..3`=a,b,c,d, `out_ready`=1 for 5 cycles. Required: `out_data` = a,b,c,d,a and `out_sel` = 0,1,2,3,0 on consecutive cycles. `in_ready` walks 0001, 0010, 0100, 1000, 0001.
3. Pointer skip: from reset, only requester 2 valid with data 7. Then `in_valid`=1010 with `in_data1`=3 and `in_data3`=9. Required: outputs 7 (`out_sel` 2), then 9 (`out_sel` 3), then 3 (`out_sel` 1).
4. Backpressure: load one word 5, then hold `out_ready`=0 for 3 cycles with `in_valid`=1111. Required: `out_valid`=1, `out_data`=5 stable, `in_ready`=0000 throughout. Raising `out_ready` accepts the next requester in the very next cycle.
5. Drain to idle: after one transfer, drop all `in_valid` with `out_ready`=1. Required: `out_valid` falls to 0 the following cycle. `out_data` and `ptr` hold.
6. Reset mid-stream: during scenario 2 at `out_sel`=2, pulse `rst_n` low between edges. Required: outputs clear immediately. After release, the first grant goes to requester 0 with `out_data`=a.
